// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int ITER_N = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: operation launch, MTHI/MTLO writes and HI/LO/status return path.
interface muldiv_if;
  import muldiv_pkg::*;

  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration over the {acc_hi, acc_lo} accumulator.
// Multiply: acc_lo holds the remaining multiplier bits; add-then-shift-right.
// Divide: acc_lo holds dividend bits shifting out as quotient bits shift in;
// acc_hi is the partial remainder (restoring subtract).
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  input  logic [DATA_W-1:0] opnd,
  output logic [DATA_W-1:0] nxt_hi,
  output logic [DATA_W-1:0] nxt_lo
);

  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   shl_rem;
  logic [DATA_W-1:0] sub_lo;
  logic              rem_ge;

  // Single iteration: shift-add for multiply, shift-subtract-compare for divide
  always_comb begin
    add_sum = {1'b0, acc_hi} + {1'b0, opnd};
    shl_rem = {acc_hi, acc_lo[DATA_W-1]};
    rem_ge  = (shl_rem >= {1'b0, opnd});
    // The remainder stays below the divisor, so the low word of the difference is exact
    sub_lo  = shl_rem[DATA_W-1:0] - opnd;
    nxt_hi  = acc_hi;
    nxt_lo  = acc_lo;
    if (is_div) begin
      nxt_hi = rem_ge ? sub_lo : shl_rem[DATA_W-1:0];
      nxt_lo = {acc_lo[DATA_W-2:0], rem_ge};
    end else if (acc_lo[0]) begin
      {nxt_hi, nxt_lo} = {add_sum, acc_lo[DATA_W-1:1]};
    end else begin
      {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Operands are reduced to magnitudes at launch; signs are re-applied in FIX.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// 64-bit product and skip the RUN state.
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic      clk,
  input logic      rstn,
  muldiv_if.slave  bus
);

  md_state_e         state;
  logic [4:0]        cnt;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              done_q;

  logic              sgn_op;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] step_hi;
  logic [DATA_W-1:0] step_lo;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic s);
    logic signed [DATA_W-1:0] sv;
    sv = $signed(v);
    return s ? $unsigned(-sv) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg64(input logic [2*DATA_W-1:0] v, input logic s);
    logic signed [2*DATA_W-1:0] sv;
    sv = $signed(v);
    return s ? $unsigned(-sv) : v;
  endfunction

  assign sgn_op = ~bus.op[0];
  assign mag_a  = cond_neg(bus.a, sgn_op & bus.a[DATA_W-1]);
  assign mag_b  = cond_neg(bus.b, sgn_op & bus.b[DATA_W-1]);

  muldiv_step u_step (
    .is_div (is_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  // Control FSM, iteration datapath and HI/LO architectural registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            cnt      <= '0;
            is_div   <= bus.op[1];
            neg_q    <= sgn_op & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
            neg_r    <= sgn_op & bus.a[DATA_W-1];
            div_zero <= bus.op[1] & (bus.b == '0);
            acc_hi   <= '0;
            acc_lo   <= bus.op[1] ? mag_a : mag_b;
            opnd     <= bus.op[1] ? mag_b : mag_a;
            state    <= RUN;
`ifdef MULDIV_FAST_MUL_EN
            if (!bus.op[1]) begin
              {acc_hi, acc_lo} <= {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
              state            <= FIX;
            end
`endif
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(ITER_N - 1)) state <= FIX;
        end
        FIX: begin
          // Divide-by-zero leaves acc_hi = |a|, so the signed remainder path yields a
          if (is_div) begin
            lo_q <= div_zero ? '1 : cond_neg(acc_lo, neg_q);
            hi_q <= cond_neg(acc_hi, neg_r);
          end else begin
            {hi_q, lo_q} <= cond_neg64({acc_hi, acc_lo}, neg_q);
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
